// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the multiply/divide sequencer:
// function codes, sequencer state encoding and MSB-based carry/borrow helpers.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int ITER   = 32;

    localparam logic [5:0] ALU_AND = 6'd36;
    localparam logic [5:0] ALU_OR  = 6'd37;
    localparam logic [5:0] ALU_ADD = 6'd32;
    localparam logic [5:0] ALU_SUB = 6'd34;
    localparam logic [5:0] ALU_SLT = 6'd42;

    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_DIVU  = 6'd27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The ALU has no carry-out, so recover it from the operand and sum MSBs.
    function automatic logic add_carry(input logic a31, input logic b31, input logic s31);
        return (a31 & b31) | ((a31 | b31) & ~s31);
    endfunction

    function automatic logic sub_borrow(input logic a31, input logic b31, input logic s31);
        return (~a31 & b31) | ((~a31 | b31) & s31);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Sequential 32-bit unsigned MULTU/DIVU that borrows the shared combinational ALU
// for one add (shift-add multiply) or subtract (restoring divide) per cycle.
module alu_muldiv_seq
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_signal,
    input  logic [DATA_W-1:0] alu_result
);

    localparam int CNT_W = $clog2(ITER);

    state_t            state;
    state_t            state_nxt;
    logic              is_mul;
    logic [DATA_W-1:0] mcand;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] step_hi;
    logic [DATA_W-1:0] step_lo;
    logic              carry;
    logic              borrow;
    logic              accept_mul;
    logic              accept_div;
    logic              err_nxt;

    assign accept_mul = (state == IDLE) && start && (op == FUNCT_MULTU);
    assign accept_div = (state == IDLE) && start && (op == FUNCT_DIVU);
    assign err_nxt    = (state == IDLE) && start && !accept_mul && !accept_div;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_nxt  = state;
        alu_signal = ALU_ADD;
        alu_a      = '0;
        alu_b      = '0;
        carry      = 1'b0;
        borrow     = 1'b0;
        step_hi    = hi;
        step_lo    = lo;
        case (state)
            IDLE: begin
                if (accept_mul || accept_div) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (is_mul) begin
                    alu_signal = ALU_ADD;
                    alu_a      = hi;
                    alu_b      = lo[0] ? mcand : '0;
                    carry      = add_carry(alu_a[DATA_W-1], alu_b[DATA_W-1], alu_result[DATA_W-1]);
                    step_hi    = {carry, alu_result[DATA_W-1:1]};
                    step_lo    = {alu_result[0], lo[DATA_W-1:1]};
                end else begin
                    alu_signal = ALU_SUB;
                    alu_a      = {hi[DATA_W-2:0], lo[DATA_W-1]};
                    alu_b      = mcand;
                    borrow     = sub_borrow(alu_a[DATA_W-1], alu_b[DATA_W-1], alu_result[DATA_W-1]);
                    // hi[31] is the 33rd remainder bit: if set, the divisor always fits.
                    if (hi[DATA_W-1] || !borrow) begin
                        step_hi = alu_result;
                        step_lo = {lo[DATA_W-2:0], 1'b1};
                    end else begin
                        step_hi = alu_a;
                        step_lo = {lo[DATA_W-2:0], 1'b0};
                    end
                end
                if (count == CNT_W'(ITER - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            is_mul <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err_nxt;
            if (accept_mul) begin
                is_mul <= 1'b1;
                hi     <= '0;
                lo     <= src_b;
                mcand  <= src_a;
                count  <= '0;
            end else if (accept_div) begin
                is_mul <= 1'b0;
                hi     <= '0;
                lo     <= src_a;
                mcand  <= src_b;
                count  <= '0;
            end else if (state == RUN) begin
                hi    <= step_hi;
                lo    <= step_lo;
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural ALU model on the shared port.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_signal;
    logic [31:0] alu_result;

    int compared   = 0;
    int mismatched = 0;

    alu_muldiv_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .hi         (hi),
        .lo         (lo),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_signal (alu_signal),
        .alu_result (alu_result)
    );

    // Shared execute-stage ALU: only ADD and SUB matter here.
    assign alu_result = (alu_signal == 6'd34) ? (alu_a - alu_b) : (alu_a + alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, optionally re-asserting start mid-run, and check
    // latency, busy length, results and the single-cycle done pulse.
    task automatic do_op(input string tag, input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int restart_at);
        int lat;
        int busy_cnt;
        int errs;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        errs = err ? 1 : 0;
        lat = 0;
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk); #1;
            if (n == restart_at) begin
                start = 1'b1; op = 6'd27; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_0003;
            end else if (n == restart_at + 1) begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (err) errs++;
            if (done) begin
                seen = 1'b1;
                lat = n;
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, lat, 32);
        chk({tag, " busy_cycles"}, busy_cnt, 33);
        chk({tag, " err"}, errs, 0);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        @(posedge clk); #1;
        chk({tag, " done_cleared"}, {31'd0, done}, 32'd0);
        chk({tag, " busy_cleared"}, {31'd0, busy}, 32'd0);
        chk({tag, " lo_held"}, lo, exp_lo);
    endtask

    initial begin
        int bcnt;
        int dcnt;
        reset = 1'b0;
        start = 1'b0;
        op    = 6'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst alu_signal", {26'd0, alu_signal}, 32'd32);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op("mul 6x7", 6'd25, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, -10);

        // Unsupported op: one err pulse, no activity, results untouched.
        @(negedge clk);
        start = 1'b1; op = 6'd32; src_a = 32'h1111_1111; src_b = 32'h2222_2222;
        @(posedge clk); #1;
        start = 1'b0;
        chk("badop err", {31'd0, err}, 32'd1);
        chk("badop busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("badop err_pulse", {31'd0, err}, 32'd0);
        chk("badop busy2", {31'd0, busy}, 32'd0);
        chk("badop hi", hi, 32'h0000_0000);
        chk("badop lo", lo, 32'h0000_002A);

        do_op("mul max", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -10);
        do_op("div 100/7", 6'd27, 32'd100, 32'd7, 32'd2, 32'd14, -10);
        do_op("div max/3", 6'd27, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'h5555_5555, -10);
        do_op("div msb", 6'd27, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 32'h0000_0000, -10);
        do_op("div 5/0", 6'd27, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, -10);
        do_op("mul restart", 6'd25, 32'h0001_2345, 32'h0000_0100, 32'h0000_0000, 32'h0123_4500, 10);

        // Reset partway through a divide aborts at once, with no done pulse.
        @(negedge clk);
        start = 1'b1; op = 6'd27; src_a = 32'd1000; src_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        reset = 1'b0;
        #1;
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort alu_signal", {26'd0, alu_signal}, 32'd32);
        chk("abort alu_a", alu_a, 32'd0);
        chk("abort alu_b", alu_b, 32'd0);
        bcnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) dcnt++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (25) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) dcnt++;
        end
        chk("abort no_done", dcnt, 0);
        chk("abort stays_idle", bcnt, 0);

        do_op("mul 3x4", 6'd25, 32'd3, 32'd4, 32'd0, 32'd12, -10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
